// File: rtl/axis_packet_gen_if.sv
// AXI4-Stream master/slave bundle for the packet generator output stream.
interface axis_packet_gen_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_gen.sv
// AXI4-Stream packet generator: counter / fixed-pattern / PRBS-31 payloads with gap and limit.
// Define PKTGEN_PRBS_EN to compile in PRBS-31 mode; otherwise mode 2 sends the fixed pattern.
module axis_packet_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  axis_aclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [15:0]           pkt_len,
  input  logic [KEEP_WIDTH-1:0] last_keep,
  input  logic [15:0]           gap_cycles,
  input  logic [31:0]           pkt_limit,
  axis_packet_gen_if.master     m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pkt_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tvalid, r_tlast, r_busy, r_done;
  logic [31:0]           r_pkt_count, w_count_nxt, w_count_inc;
  logic [15:0]           r_beat_idx, w_idx_nxt;
  logic [15:0]           r_gap_cnt, w_gap_nxt;
  logic                  w_beat_done, w_load, w_new_pkt, w_start_run;

  // Per-packet configuration snapshot
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_pattern;
  logic [15:0]           r_len_m1, r_gap;
  logic [KEEP_WIDTH-1:0] r_last_keep;

  logic [1:0]            w_mode;
  logic [DATA_WIDTH-1:0] w_pattern, w_cnt_word, w_payload;
  logic [15:0]           w_len_m1_in, w_len_m1;
  logic [KEEP_WIDTH-1:0] w_keep_in, w_lkeep, w_keep;
  logic                  w_last;

  assign w_beat_done = (r_state == S_SEND) && r_tvalid && m_axis.tready;
  assign w_count_inc = (r_pkt_count == '1) ? r_pkt_count : r_pkt_count + 32'd1;
  assign w_len_m1_in = (pkt_len == 16'd0) ? 16'd0 : pkt_len - 16'd1;
  assign w_keep_in   = (last_keep == '0) ? '1 : last_keep;

  always_ff @(posedge axis_aclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus counter / beat-load decisions
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_new_pkt   = 1'b0;
    w_start_run = 1'b0;
    w_count_nxt = r_pkt_count;
    w_idx_nxt   = r_beat_idx;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_SEND;
          w_start_run = 1'b1;
          w_new_pkt   = 1'b1;
          w_load      = 1'b1;
          w_count_nxt = 32'd0;
          w_idx_nxt   = 16'd0;
        end
      end
      S_SEND: begin
        if (w_beat_done) begin
          if (r_tlast) begin
            w_count_nxt = w_count_inc;
            if ((pkt_limit != 32'd0) && (w_count_inc == pkt_limit)) begin
              w_state_nxt = S_DONE;
            end else if (r_gap != 16'd0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = r_gap;
            end else if (enable) begin
              w_new_pkt = 1'b1;
              w_load    = 1'b1;
              w_idx_nxt = 16'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_load    = 1'b1;
            w_idx_nxt = r_beat_idx + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= 16'd1) begin
          if (enable) begin
            w_state_nxt = S_SEND;
            w_new_pkt   = 1'b1;
            w_load      = 1'b1;
            w_idx_nxt   = 16'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
          w_gap_nxt = 16'd0;
        end else begin
          w_gap_nxt = r_gap_cnt - 16'd1;
        end
      end
      S_DONE: begin
        if (!enable) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The first beat of a packet uses live inputs; later beats use the snapshot
  always_comb begin
    w_mode    = w_new_pkt ? mode        : r_mode;
    w_pattern = w_new_pkt ? pattern     : r_pattern;
    w_len_m1  = w_new_pkt ? w_len_m1_in : r_len_m1;
    w_lkeep   = w_new_pkt ? w_keep_in   : r_last_keep;
    w_last    = (w_idx_nxt == w_len_m1);
    w_keep    = w_last ? w_lkeep : '1;
    w_cnt_word        = w_pattern;
    w_cnt_word[31:0]  = {w_count_nxt[15:0], w_idx_nxt};
  end

`ifdef PKTGEN_PRBS_EN
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  logic [30:0]           r_prbs, w_prbs_adv;
  logic [DATA_WIDTH-1:0] w_prbs_word;

  // x^31 + x^28 + 1, one bit per step, LSB of the word first
  always_comb begin
    logic [30:0] v_s;
    logic        v_b;
    v_s         = w_start_run ? PRBS_SEED : r_prbs;
    w_prbs_word = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      v_b            = v_s[30] ^ v_s[27];
      w_prbs_word[i] = v_b;
      v_s            = {v_s[29:0], v_b};
    end
    w_prbs_adv = v_s;
  end

  always_ff @(posedge axis_aclk) begin
    if (reset)       r_prbs <= PRBS_SEED;
    else if (w_load) r_prbs <= w_prbs_adv;
  end
`endif

  always_comb begin
    case (w_mode)
      2'd1:    w_payload = w_pattern;
`ifdef PKTGEN_PRBS_EN
      2'd2:    w_payload = w_prbs_word;
`else
      2'd2:    w_payload = w_pattern;
`endif
      default: w_payload = w_cnt_word;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pkt_count <= 32'd0;
      r_beat_idx  <= 16'd0;
      r_gap_cnt   <= 16'd0;
      r_mode      <= 2'd0;
      r_pattern   <= '0;
      r_len_m1    <= 16'd0;
      r_gap       <= 16'd0;
      r_last_keep <= '0;
    end else begin
      r_tvalid    <= (w_state_nxt == S_SEND);
      r_busy      <= (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
      r_done      <= (w_state_nxt == S_DONE);
      r_pkt_count <= w_count_nxt;
      r_beat_idx  <= w_idx_nxt;
      r_gap_cnt   <= w_gap_nxt;
      if (w_new_pkt) begin
        r_mode      <= mode;
        r_pattern   <= pattern;
        r_len_m1    <= w_len_m1_in;
        r_gap       <= gap_cycles;
        r_last_keep <= w_keep_in;
      end
      if (w_load) begin
        r_tdata <= w_payload;
        r_tkeep <= w_keep;
        r_tlast <= w_last;
      end
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = r_tkeep;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pkt_count     = r_pkt_count;

endmodule
